wb_bus_decoder: RTL and testbench
=================================

// Module: wb_bus_decoder
// PURPOSE
//  Parametrised Wishbone single-master to N-slave address decoder for the SoC peripheral bus.
//  - Decodes the master address against per-slave base/end ranges and forwards the cycle to one slave.
//  - Subtracts each slave's base address before forwarding.
//  - Returns the slave's data and ack/err to the master.
//  - Adds two things the hand-written mux lacks: registered slave select, and a per-transaction timeout watchdog.
// PARAMETERS
//  N_SLV     6              number of slave ports (1..16)
//  ADDR_W    24             Wishbone address width
//  DATA_W    16             Wishbone data width
//  SEL_W     2              byte-select width (DATA_W/8)
//  TIMEOUT   255            max wait cycles in ACTIVE before bus error (>=1)
//  SLV_BASE  {N_SLV*ADDR_W} packed base addresses; slave i at [i*ADDR_W +: ADDR_W]
//  SLV_END   {N_SLV*ADDR_W} packed inclusive end addresses, same packing
// PORTS
//  i_clk         in   1              bus clock
//  i_rst_n       in   1              async active-low reset
//  i_m_cyc       in   1              master cycle
//  i_m_stb       in   1              master strobe
//  i_m_we        in   1              master write enable
//  i_m_adr       in   ADDR_W         master address
//  i_m_dat       in   DATA_W         master write data
//  i_m_sel       in   SEL_W          master byte select
//  o_m_dat       out  DATA_W         read data to master
//  o_m_ack       out  1              ack to master
//  o_m_err       out  1              error to master (unmapped, timeout or slave err)
//  o_s_cyc       out  1              shared cycle to slaves
//  o_s_stb       out  N_SLV          one-hot per-slave strobe
//  o_s_we        out  1              shared write enable
//  o_s_adr       out  N_SLV*ADDR_W   per-slave address, i_m_adr - SLV_BASE[i]
//  o_s_dat       out  DATA_W         shared write data
//  o_s_sel       out  SEL_W          shared byte select
//  i_s_dat       in   N_SLV*DATA_W   packed slave read data
//  i_s_ack       in   N_SLV          per-slave ack
//  i_s_err       in   N_SLV          per-slave err
//  o_tmo_cnt     out  8              saturating count of timeouts
//  o_err_adr     out  ADDR_W         master address of the last errored transaction
// BEHAVIOUR
//  Reset (async, i_rst_n=0)
//  - FSM=IDLE; o_s_stb=0, o_m_ack=0, o_m_err=0, o_tmo_cnt=0, o_err_adr=0, o_m_dat=0.
//  - Reset mid-transaction aborts it immediately; no ack or err is issued.
//  Decode
//  - Combinational range match: SLV_BASE[i] <= adr <= SLV_END[i].
//  - Overlapping ranges: lowest index wins. No match = unmapped.
//  FSM states IDLE / ACTIVE / ERR
//  - IDLE: on cyc&stb, a match latches sel_idx and goes to ACTIVE; no match goes to ERR.
//  - ACTIVE: o_s_stb[sel_idx]=1 and o_s_cyc=1; wait counter increments every cycle.
//    - i_s_ack[sel_idx]: o_m_ack=1 and o_m_dat=i_s_dat[sel_idx], combinational in the same cycle; go to IDLE.
//    - i_s_err[sel_idx]: o_m_err=1 combinationally; go to IDLE; o_err_adr latched.
//    - Ack and err together: err wins; no ack.
//    - Counter == TIMEOUT and no ack: o_m_err=1 for 1 cycle, o_s_stb dropped, o_tmo_cnt++ (saturates at 255), o_err_adr latched, go to IDLE.
//    - Master drops cyc: abort to IDLE; no ack or err; counter cleared.
//  - ERR: o_m_err=1 for exactly 1 cycle, o_err_adr latched; go to IDLE.
//  Other rules
//  - Acks or errs from unselected slaves are ignored in every state.
//  - Latency: unmapped errors 1 cycle after stb; mapped slave sees stb 1 cycle after master stb.
//  - Back-to-back: after returning to IDLE, a still-asserted stb starts a new decode on the next cycle.
//  - o_m_dat = 0 whenever o_m_ack=0.
//  - Address subtraction is modulo 2^ADDR_W; the wait counter is $clog2(TIMEOUT+1) bits wide.
// STRUCTURE
//  - Shared package wb_pkg: FSM state enum, WB width defaults, SoC address-map constants
//    (UART, TIMER, IRQC, SPI, SDRAM, ROM base/end).
//  - One sub-module, wb_addr_match: combinational priority range decoder that outputs hit and idx.
// TESTING
//  1. Map UART 0x002000-0x002003; read 0x002002; slave acks after 1 cycle
//     -> o_s_stb[0]=1, o_s_adr[0]=0x000002, o_m_ack with the slave's data.
//  2. Access 0x003000 (unmapped) -> o_m_err=1 for exactly 1 cycle, no o_s_stb, o_err_adr=0x003000.
//  3. TIMEOUT=8; slave never acks -> o_m_err on cycle 9 of ACTIVE, o_tmo_cnt=1, stb dropped.
//  4. Slave asserts ack and err in the same cycle -> o_m_err=1, o_m_ack=0.
//  5. Master drops cyc mid-ACTIVE, then i_rst_n pulsed low mid-ACTIVE
//     -> IDLE each time, no ack/err; all outputs at reset values during reset.
//  6. Overlapping ranges for slaves 1 and 3 at 0x100000 -> only o_s_stb[1]; 300 timeouts -> o_tmo_cnt=255.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: decoder FSM states, bus width defaults and the SoC peripheral map.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StErr
  } wb_state_e;

  localparam int unsigned WbAddrW  = 24;
  localparam int unsigned WbDataW  = 16;
  localparam int unsigned WbSelW   = WbDataW / 8;
  localparam int unsigned WbNumSlv = 6;

  localparam logic [WbAddrW-1:0] UartBase  = 24'h002000;
  localparam logic [WbAddrW-1:0] UartEnd   = 24'h002003;
  localparam logic [WbAddrW-1:0] TimerBase = 24'h002100;
  localparam logic [WbAddrW-1:0] TimerEnd  = 24'h0021FF;
  localparam logic [WbAddrW-1:0] IrqcBase  = 24'h002200;
  localparam logic [WbAddrW-1:0] IrqcEnd   = 24'h0022FF;
  localparam logic [WbAddrW-1:0] SpiBase   = 24'h002300;
  localparam logic [WbAddrW-1:0] SpiEnd    = 24'h00230F;
  localparam logic [WbAddrW-1:0] SdramBase = 24'h100000;
  localparam logic [WbAddrW-1:0] SdramEnd  = 24'h1FFFFF;
  localparam logic [WbAddrW-1:0] RomBase   = 24'hF00000;
  localparam logic [WbAddrW-1:0] RomEnd    = 24'hFFFFFF;

  // Slave 0 sits in the lowest slice.
  localparam logic [WbNumSlv*WbAddrW-1:0] SocSlvBase =
      {RomBase, SdramBase, SpiBase, IrqcBase, TimerBase, UartBase};
  localparam logic [WbNumSlv*WbAddrW-1:0] SocSlvEnd =
      {RomEnd, SdramEnd, SpiEnd, IrqcEnd, TimerEnd, UartEnd};

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority range decoder: reports whether the address falls in any slave window
// and the lowest-numbered slave whose inclusive [base, end] window contains it.
module wb_addr_match #(
  parameter int unsigned NumSlv = 6,
  parameter int unsigned AddrW  = 24,
  parameter int unsigned IdxW   = 3,
  parameter logic [NumSlv*AddrW-1:0] SlvBase = '0,
  parameter logic [NumSlv*AddrW-1:0] SlvEnd  = '0
) (
  input  logic [AddrW-1:0] adr_i,
  output logic             hit_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = int'(NumSlv) - 1; i >= 0; i--) begin
      if ((adr_i >= SlvBase[i*AddrW +: AddrW]) && (adr_i <= SlvEnd[i*AddrW +: AddrW])) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_bus_decoder.sv
// Wishbone single-master to N-slave decoder with registered slave select, base-address
// subtraction, per-transaction timeout watchdog and error reporting.
module wb_bus_decoder
  import wb_pkg::*;
#(
  parameter int unsigned N_SLV   = WbNumSlv,
  parameter int unsigned ADDR_W  = WbAddrW,
  parameter int unsigned DATA_W  = WbDataW,
  parameter int unsigned SEL_W   = WbSelW,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = SocSlvBase,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_END  = SocSlvEnd
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_m_cyc,
  input  logic                    i_m_stb,
  input  logic                    i_m_we,
  input  logic [ADDR_W-1:0]       i_m_adr,
  input  logic [DATA_W-1:0]       i_m_dat,
  input  logic [SEL_W-1:0]        i_m_sel,
  output logic [DATA_W-1:0]       o_m_dat,
  output logic                    o_m_ack,
  output logic                    o_m_err,
  output logic                    o_s_cyc,
  output logic [N_SLV-1:0]        o_s_stb,
  output logic                    o_s_we,
  output logic [N_SLV*ADDR_W-1:0] o_s_adr,
  output logic [DATA_W-1:0]       o_s_dat,
  output logic [SEL_W-1:0]        o_s_sel,
  input  logic [N_SLV*DATA_W-1:0] i_s_dat,
  input  logic [N_SLV-1:0]        i_s_ack,
  input  logic [N_SLV-1:0]        i_s_err,
  output logic [7:0]              o_tmo_cnt,
  output logic [ADDR_W-1:0]       o_err_adr
);

  localparam int unsigned IdxW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  wb_state_e            state_q, state_d;
  logic [IdxW-1:0]      sel_q, sel_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]    adr_q, adr_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [ADDR_W-1:0]    err_adr_q, err_adr_d;

  logic                 hit;
  logic [IdxW-1:0]      idx;
  logic                 sel_ack, sel_err;
  logic [DATA_W-1:0]    sel_dat;
  logic                 stb_en;

  wb_addr_match #(
    .NumSlv  (N_SLV),
    .AddrW   (ADDR_W),
    .IdxW    (IdxW),
    .SlvBase (SLV_BASE),
    .SlvEnd  (SLV_END)
  ) u_addr_match (
    .adr_i (i_m_adr),
    .hit_o (hit),
    .idx_o (idx)
  );

  for (genvar g = 0; g < N_SLV; g++) begin : g_s_adr
    assign o_s_adr[g*ADDR_W +: ADDR_W] = i_m_adr - SLV_BASE[g*ADDR_W +: ADDR_W];
  end

  // Only the latched slave's response is visible; everything else is ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q == IdxW'(i)) begin
        sel_ack = i_s_ack[i];
        sel_err = i_s_err[i];
        sel_dat = i_s_dat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    tmo_d     = tmo_q;
    err_adr_d = err_adr_q;
    o_m_ack   = 1'b0;
    o_m_err   = 1'b0;
    o_s_cyc   = 1'b0;
    stb_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_m_cyc && i_m_stb) begin
          adr_d = i_m_adr;
          if (hit) begin
            sel_d   = idx;
            state_d = StActive;
          end else begin
            state_d = StErr;
          end
        end
      end
      StActive: begin
        o_s_cyc = i_m_cyc;
        cnt_d   = cnt_q + 1'b1;
        if (!i_m_cyc) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (sel_err) begin
          stb_en    = 1'b1;
          o_m_err   = 1'b1;
          err_adr_d = adr_q;
          state_d   = StIdle;
        end else if (sel_ack) begin
          stb_en  = 1'b1;
          o_m_ack = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          o_m_err   = 1'b1;
          err_adr_d = adr_q;
          tmo_d     = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          state_d   = StIdle;
        end else begin
          stb_en = 1'b1;
        end
      end
      StErr: begin
        o_m_err   = 1'b1;
        err_adr_d = adr_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_s_stb = '0;
    if (stb_en) begin
      o_s_stb[sel_q] = 1'b1;
    end
  end

  assign o_m_dat   = o_m_ack ? sel_dat : '0;
  assign o_s_we    = i_m_we;
  assign o_s_dat   = i_m_dat;
  assign o_s_sel   = i_m_sel;
  assign o_tmo_cnt = tmo_q;
  assign o_err_adr = err_adr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      adr_q     <= '0;
      tmo_q     <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      tmo_q     <= tmo_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Randomized bench for wb_bus_decoder: a transaction-level model predicts every cycle's outputs.
module tb_wb_bus_decoder;

  localparam int unsigned NS  = 6;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned SW  = 2;
  localparam int unsigned TMO = 8;

  // Slaves 1 and 3 overlap at 0x100000; 0x003000 is a hole.
  localparam logic [NS*AW-1:0] BASE_P =
      {24'hF00000, 24'h002300, 24'h0F0000, 24'h002100, 24'h100000, 24'h002000};
  localparam logic [NS*AW-1:0] END_P =
      {24'hFFFFFF, 24'h00230F, 24'h1FFFFF, 24'h0021FF, 24'h10FFFF, 24'h002003};

  logic clk = 1'b0;
  logic rst_n;
  logic m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] o_m_dat;
  logic o_m_ack, o_m_err, o_s_cyc, o_s_we;
  logic [NS-1:0] o_s_stb;
  logic [NS*AW-1:0] o_s_adr;
  logic [DW-1:0] o_s_dat;
  logic [SW-1:0] o_s_sel;
  logic [NS*DW-1:0] s_dat;
  logic [NS-1:0] s_ack, s_err;
  logic [7:0] o_tmo_cnt;
  logic [AW-1:0] o_err_adr;

  always #5 clk = ~clk;

  wb_bus_decoder #(
    .N_SLV    (NS),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SEL_W    (SW),
    .TIMEOUT  (TMO),
    .SLV_BASE (BASE_P),
    .SLV_END  (END_P)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_m_cyc   (m_cyc),
    .i_m_stb   (m_stb),
    .i_m_we    (m_we),
    .i_m_adr   (m_adr),
    .i_m_dat   (m_dat),
    .i_m_sel   (m_sel),
    .o_m_dat   (o_m_dat),
    .o_m_ack   (o_m_ack),
    .o_m_err   (o_m_err),
    .o_s_cyc   (o_s_cyc),
    .o_s_stb   (o_s_stb),
    .o_s_we    (o_s_we),
    .o_s_adr   (o_s_adr),
    .o_s_dat   (o_s_dat),
    .o_s_sel   (o_s_sel),
    .i_s_dat   (s_dat),
    .i_s_ack   (s_ack),
    .i_s_err   (s_err),
    .o_tmo_cnt (o_tmo_cnt),
    .o_err_adr (o_err_adr)
  );

  // Model expectations for the current cycle.
  logic          exp_ack, exp_err, exp_scyc, exp_dc;
  logic [DW-1:0] exp_dat;
  logic [NS-1:0] exp_stb;
  logic [AW-1:0] exp_sadr;
  int            exp_idx;
  logic [7:0]    m_tmo;
  logic [AW-1:0] m_err_adr;
  bit            pend_err, pend_tmo, chk_en, fix_dat;
  logic [AW-1:0] pend_adr;

  int n_cmp = 0;
  int n_bad = 0;

  int            last_len;
  logic          last_ack, last_err;
  logic [DW-1:0] last_dat;
  logic [NS-1:0] last_stb;
  logic [AW-1:0] last_sadr0, last_eadr;
  logic [7:0]    last_tmo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ack", 64'(o_m_ack), 64'(exp_ack));
      chk("m_err", 64'(o_m_err), 64'(exp_err));
      chk("m_dat", 64'(o_m_dat), 64'(exp_dat));
      chk("tmo_cnt", 64'(o_tmo_cnt), 64'(m_tmo));
      chk("err_adr", 64'(o_err_adr), 64'(m_err_adr));
      if (!exp_dc) begin
        chk("s_stb", 64'(o_s_stb), 64'(exp_stb));
        chk("s_cyc", 64'(o_s_cyc), 64'(exp_scyc));
        if (exp_scyc) begin
          chk("s_adr", 64'(o_s_adr[exp_idx*AW +: AW]), 64'(exp_sadr));
          chk("s_we", 64'(o_s_we), 64'(m_we));
          chk("s_dat", 64'(o_s_dat), 64'(m_dat));
          chk("s_sel", 64'(o_s_sel), 64'(m_sel));
        end
      end
    end
  end

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++) begin
      if (a >= BASE_P[i*AW +: AW] && a <= END_P[i*AW +: AW]) return i;
    end
    return -1;
  endfunction

  task automatic exp_idle();
    exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_stb = '0;
    exp_scyc = 1'b0; exp_dc = 1'b0;
  endtask

  // Registered side effects of the previous cycle become visible in this one.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (pend_err) begin m_err_adr = pend_adr; pend_err = 1'b0; end
    if (pend_tmo) begin
      if (m_tmo != 8'hFF) m_tmo = m_tmo + 8'd1;
      pend_tmo = 1'b0;
    end
  endtask

  task automatic noise(input int keep_idx);
    s_ack = NS'($urandom);
    s_err = NS'($urandom & $urandom);
    s_dat = {$urandom, $urandom, $urandom};
    if (keep_idx >= 0) begin
      s_ack[keep_idx] = 1'b0;
      s_err[keep_idx] = 1'b0;
    end
  endtask

  task automatic capture(input int k);
    @(negedge clk);
    #1;
    last_len = k; last_ack = o_m_ack; last_err = o_m_err; last_dat = o_m_dat;
    last_stb = o_s_stb; last_sadr0 = o_s_adr[AW-1:0]; last_tmo = o_tmo_cnt;
    last_eadr = o_err_adr;
  endtask

  task automatic idle_cycle();
    next_cycle();
    m_cyc = 1'b0; m_stb = 1'b0;
    noise(-1);
    exp_idle();
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 never respond. delay: ACTIVE cycle of the response.
  task automatic txn(input logic [AW-1:0] adr, input int kind, input int delay,
                     input int abort_at, input bit abort_rst, input bit gap);
    int idx;
    idx = decode(adr);
    next_cycle();
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = 1'($urandom);
    m_dat = DW'($urandom); m_sel = SW'($urandom);
    noise(-1);
    exp_idle();
    if (idx < 0) begin
      next_cycle();
      noise(-1);
      exp_idle();
      exp_err = 1'b1; pend_err = 1'b1; pend_adr = adr;
      capture(1);
    end else begin
      for (int k = 1; k <= TMO + 1; k++) begin
        next_cycle();
        noise(idx);
        exp_idle();
        exp_stb = NS'(1) << idx; exp_scyc = 1'b1; exp_idx = idx;
        exp_sadr = adr - BASE_P[idx*AW +: AW];
        if (k == abort_at) begin
          if (abort_rst) begin
            rst_n = 1'b0;
            exp_stb = '0; exp_scyc = 1'b0;
            m_tmo = '0; m_err_adr = '0; pend_err = 1'b0; pend_tmo = 1'b0;
          end else begin
            m_cyc = 1'b0; m_stb = 1'b0; exp_dc = 1'b1;
          end
          capture(k);
          if (abort_rst) begin
            next_cycle();
            rst_n = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
            exp_idle();
          end
          break;
        end
        if (kind != 3 && k == delay) begin
          if (kind != 1) s_ack[idx] = 1'b1;
          if (kind != 0) s_err[idx] = 1'b1;
          if (fix_dat) s_dat[idx*DW +: DW] = 16'hBEEF;
          if (kind == 0) begin
            exp_ack = 1'b1; exp_dat = s_dat[idx*DW +: DW];
          end else begin
            exp_err = 1'b1; pend_err = 1'b1; pend_adr = adr;
          end
          capture(k);
          break;
        end
        if (k == TMO + 1) begin
          exp_err = 1'b1; exp_stb = '0;
          pend_err = 1'b1; pend_adr = adr; pend_tmo = 1'b1;
          capture(k);
        end
      end
    end
    if (gap) idle_cycle();
  endtask

  function automatic logic [AW-1:0] pick_adr();
    int s;
    logic [AW-1:0] b, e;
    s = $urandom_range(0, NS - 1);
    b = BASE_P[s*AW +: AW];
    e = END_P[s*AW +: AW];
    case ($urandom_range(0, 3))
      0:       return AW'($urandom);
      1:       return b + AW'($urandom_range(0, 32'(e - b)));
      2: begin
        case ($urandom_range(0, 3))
          0:       return b - 1'b1;
          1:       return b;
          2:       return e;
          default: return e + 1'b1;
        endcase
      end
      default: return 24'h003000 + AW'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ab;
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat = '0; s_ack = '0; s_err = '0;
    pend_err = 1'b0; pend_tmo = 1'b0; pend_adr = '0; m_tmo = '0; m_err_adr = '0;
    fix_dat = 1'b0; exp_idx = 0; exp_sadr = '0;
    exp_idle();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_stb", 64'(o_s_stb), 64'(0));
    chk("rst_err_adr", 64'(o_err_adr), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // UART read, slave acks on the second ACTIVE cycle.
    fix_dat = 1'b1;
    txn(24'h002002, 0, 2, 0, 1'b0, 1'b1);
    fix_dat = 1'b0;
    chk("t1_len", 64'(last_len), 64'(2));
    chk("t1_ack", 64'(last_ack), 64'(1));
    chk("t1_dat", 64'(last_dat), 64'h BEEF);
    chk("t1_stb", 64'(last_stb), 64'b000001);
    chk("t1_sadr", 64'(last_sadr0), 64'h000002);

    // Unmapped access.
    txn(24'h003000, 0, 1, 0, 1'b0, 1'b1);
    chk("t2_err", 64'(last_err), 64'(1));
    chk("t2_stb", 64'(last_stb), 64'(0));
    @(negedge clk);
    #1;
    chk("t2_err_adr", 64'(o_err_adr), 64'h003000);
    chk("t2_err_once", 64'(o_m_err), 64'(0));

    // Timeout on the ninth ACTIVE cycle.
    txn(24'h002100, 3, 0, 0, 1'b0, 1'b1);
    chk("t3_len", 64'(last_len), 64'(9));
    chk("t3_err", 64'(last_err), 64'(1));
    chk("t3_stb", 64'(last_stb), 64'(0));
    @(negedge clk);
    #1;
    chk("t3_tmo", 64'(o_tmo_cnt), 64'(1));

    // Ack and err together.
    txn(24'h002300, 2, 3, 0, 1'b0, 1'b1);
    chk("t4_err", 64'(last_err), 64'(1));
    chk("t4_ack", 64'(last_ack), 64'(0));
    chk("t4_dat", 64'(last_dat), 64'(0));

    // Master abort, then reset mid-ACTIVE.
    txn(24'h002001, 0, 6, 3, 1'b0, 1'b1);
    chk("t5a_ack", 64'(last_ack), 64'(0));
    chk("t5a_err", 64'(last_err), 64'(0));
    txn(24'hF00010, 0, 6, 4, 1'b1, 1'b1);
    chk("t5b_ack", 64'(last_ack), 64'(0));
    chk("t5b_err", 64'(last_err), 64'(0));
    chk("t5b_stb", 64'(last_stb), 64'(0));
    chk("t5b_tmo", 64'(last_tmo), 64'(0));
    chk("t5b_eadr", 64'(last_eadr), 64'(0));

    // Overlap priority and timeout-counter saturation.
    txn(24'h100000, 0, 1, 0, 1'b0, 1'b0);
    chk("t6_stb", 64'(last_stb), 64'b000010);
    repeat (300) txn(24'h100000, 3, 0, 0, 1'b0, 1'b0);
    idle_cycle();
    @(negedge clk);
    #1;
    chk("t6_tmo_sat", 64'(o_tmo_cnt), 64'(255));

    repeat (400) begin
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TMO + 1)) : 0;
      txn(pick_adr(), int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 3)), ab,
          (ab != 0) && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    idle_cycle();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
